uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and valid/ready byte output
// The line is synchronized, start bits are qualified at half-bit, and bytes are held until consumed.

module uart_rx #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_n_i,
  input  logic       uart_rx_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  input  logic       uart_ready_i,
  output logic       uart_frame_err_o,
  output logic       uart_overrun_o,
  output logic       uart_busy_o
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int TW  = $clog2(DIV);
  localparam logic [TW-1:0] HALF_M1 = TW'(DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(DIV - 1);

  generate
    if (DIV < 4) begin : g_div_check
      $error("uart_rx: clock/baud ratio too small, DIV must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_rxs;
  logic [TW-1:0]   r_timer;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_dat;
  logic            r_valid;
  logic            r_frame_err;
  logic            r_overrun;

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= uart_rx_i;
      r_rxs   <= r_sync1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_idx       <= 3'd0;
      r_shift     <= 8'h00;
      r_dat       <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (r_valid && uart_ready_i) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            r_state <= S_START;
            r_timer <= HALF_M1;
          end
        end
        S_START: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
          end else if (r_rxs) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DATA;
            r_timer <= FULL_M1;
            r_idx   <= 3'd0;
          end
        end
        S_DATA: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
          end else begin
            r_shift[r_idx] <= r_rxs;
            r_timer        <= FULL_M1;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
          end else if (r_rxs) begin
            // A held byte that is being consumed this cycle frees the slot.
            if (!r_valid || uart_ready_i) begin
              r_dat   <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
            r_state <= S_IDLE;
          end else begin
            r_frame_err <= 1'b1;
            r_state     <= S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          if (r_rxs) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uart_dat_o       = r_dat;
  assign uart_valid_o     = r_valid;
  assign uart_frame_err_o = r_frame_err;
  assign uart_overrun_o   = r_overrun;
  assign uart_busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at 12 MHz / 115200 baud
// Bit times are counted in clocks: 104 cycles nominal, 102 and 106 for the tolerance case.

`timescale 1ns/1ps

module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] dat;
  logic       valid;
  logic       ready;
  logic       ferr;
  logic       ovr;
  logic       busy;

  int cmp_cnt;
  int mis_cnt;
  int cyc;
  int n_valid;
  int n_ferr;
  int n_ovr;
  int t_valid;
  logic [7:0] rise_dat;
  logic prev_valid;

  uart_rx #(.CLK_HZ(12000000), .BAUD(115200)) dut (
    .sys_clk_i       (clk),
    .sys_rst_n_i     (rst_n),
    .uart_rx_i       (rx),
    .uart_dat_o      (dat),
    .uart_valid_o    (valid),
    .uart_ready_i    (ready),
    .uart_frame_err_o(ferr),
    .uart_overrun_o  (ovr),
    .uart_busy_o     (busy)
  );

  initial clk = 1'b0;
  always #41.667 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Event monitor sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (valid && !prev_valid) begin
      n_valid  = n_valid + 1;
      t_valid  = cyc;
      rise_dat = dat;
    end
    if (ferr) n_ferr = n_ferr + 1;
    if (ovr) n_ovr = n_ovr + 1;
    prev_valid = valid;
  end

  task automatic clear_counts();
    n_valid = 0;
    n_ferr  = 0;
    n_ovr   = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input int bc, input logic stop_val, output int fall_cyc);
    logic [7:0] v;
    v = d;
    @(negedge clk);
    fall_cyc = cyc;
    rx = 1'b0;
    idle(bc);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      idle(bc);
    end
    rx = stop_val;
    idle(bc);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(5);
    cmp_cnt++; if (dat !== 8'h00) begin mis_cnt++; $display("FAIL reset_dat: got %h want 00", dat); end
    cmp_cnt++; if (valid !== 1'b0) begin mis_cnt++; $display("FAIL reset_valid: got %b want 0", valid); end
    cmp_cnt++; if (ferr !== 1'b0) begin mis_cnt++; $display("FAIL reset_ferr: got %b want 0", ferr); end
    cmp_cnt++; if (ovr !== 1'b0) begin mis_cnt++; $display("FAIL reset_ovr: got %b want 0", ovr); end
    cmp_cnt++; if (busy !== 1'b0) begin mis_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    idle(20);
  endtask

  task automatic test_single();
    int fall;
    int lat;
    ready = 1'b1;
    clear_counts();
    send_byte(8'h55, 104, 1'b1, fall);
    idle(50);
    lat = t_valid - fall;
    cmp_cnt++; if (n_valid !== 1) begin mis_cnt++; $display("FAIL single_count: got %0d want 1", n_valid); end
    cmp_cnt++; if (rise_dat !== 8'h55) begin mis_cnt++; $display("FAIL single_dat: got %h want 55", rise_dat); end
    cmp_cnt++; if (lat < 989 || lat > 991) begin mis_cnt++; $display("FAIL single_latency: got %0d want 989..991", lat); end
    cmp_cnt++; if (n_ferr !== 0) begin mis_cnt++; $display("FAIL single_ferr: got %0d want 0", n_ferr); end
    cmp_cnt++; if (valid !== 1'b0) begin mis_cnt++; $display("FAIL single_valid_clear: got %b want 0", valid); end
  endtask

  task automatic test_back_to_back_overrun();
    int fall;
    ready = 1'b0;
    clear_counts();
    send_byte(8'hA3, 104, 1'b1, fall);
    send_byte(8'h0F, 104, 1'b1, fall);
    idle(20);
    cmp_cnt++; if (dat !== 8'hA3) begin mis_cnt++; $display("FAIL ovr_dat_held: got %h want a3", dat); end
    cmp_cnt++; if (valid !== 1'b1) begin mis_cnt++; $display("FAIL ovr_valid_held: got %b want 1", valid); end
    cmp_cnt++; if (n_ovr !== 1) begin mis_cnt++; $display("FAIL ovr_pulses: got %0d want 1", n_ovr); end
    cmp_cnt++; if (n_valid !== 1) begin mis_cnt++; $display("FAIL ovr_valid_rises: got %0d want 1", n_valid); end
    ready = 1'b1;
    idle(1);
    cmp_cnt++; if (valid !== 1'b0) begin mis_cnt++; $display("FAIL ovr_valid_drop: got %b want 0", valid); end
    cmp_cnt++; if (dat !== 8'hA3) begin mis_cnt++; $display("FAIL ovr_dat_after: got %h want a3", dat); end
    idle(20);
  endtask

  task automatic test_glitch();
    clear_counts();
    rx = 1'b0;
    idle(10);
    cmp_cnt++; if (busy !== 1'b1) begin mis_cnt++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
    idle(10);
    rx = 1'b1;
    idle(38);
    cmp_cnt++; if (busy !== 1'b0) begin mis_cnt++; $display("FAIL glitch_idle_by_58: got %b want 0", busy); end
    idle(1100);
    cmp_cnt++; if (n_valid !== 0) begin mis_cnt++; $display("FAIL glitch_valid: got %0d want 0", n_valid); end
    cmp_cnt++; if (n_ferr !== 0) begin mis_cnt++; $display("FAIL glitch_ferr: got %0d want 0", n_ferr); end
  endtask

  task automatic test_break();
    int fall;
    clear_counts();
    send_byte(8'h81, 104, 1'b0, fall);
    rx = 1'b0;
    idle(30 * 104);
    cmp_cnt++; if (busy !== 1'b1) begin mis_cnt++; $display("FAIL break_busy_low: got %b want 1", busy); end
    rx = 1'b1;
    idle(300);
    cmp_cnt++; if (n_ferr !== 1) begin mis_cnt++; $display("FAIL break_ferr_count: got %0d want 1", n_ferr); end
    cmp_cnt++; if (n_valid !== 0) begin mis_cnt++; $display("FAIL break_valid: got %0d want 0", n_valid); end
    cmp_cnt++; if (busy !== 1'b0) begin mis_cnt++; $display("FAIL break_busy_idle: got %b want 0", busy); end
    send_byte(8'h42, 104, 1'b1, fall);
    idle(50);
    cmp_cnt++; if (n_valid !== 1) begin mis_cnt++; $display("FAIL break_next_count: got %0d want 1", n_valid); end
    cmp_cnt++; if (rise_dat !== 8'h42) begin mis_cnt++; $display("FAIL break_next_dat: got %h want 42", rise_dat); end
  endtask

  task automatic test_reset_mid_frame();
    int fall;
    @(negedge clk);
    rx = 1'b0;
    idle(104);
    rx = 1'b1;
    idle(4 * 104 + 50);
    cmp_cnt++; if (busy !== 1'b1) begin mis_cnt++; $display("FAIL midrst_busy_pre: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    cmp_cnt++; if (busy !== 1'b0) begin mis_cnt++; $display("FAIL midrst_busy: got %b want 0", busy); end
    cmp_cnt++; if (dat !== 8'h00) begin mis_cnt++; $display("FAIL midrst_dat: got %h want 00", dat); end
    cmp_cnt++; if (valid !== 1'b0) begin mis_cnt++; $display("FAIL midrst_valid: got %b want 0", valid); end
    idle(3);
    clear_counts();
    rst_n = 1'b1;
    idle(5 * 104);
    send_byte(8'h3C, 104, 1'b1, fall);
    idle(50);
    cmp_cnt++; if (n_valid !== 1) begin mis_cnt++; $display("FAIL midrst_next_count: got %0d want 1", n_valid); end
    cmp_cnt++; if (rise_dat !== 8'h3C) begin mis_cnt++; $display("FAIL midrst_next_dat: got %h want 3c", rise_dat); end
    cmp_cnt++; if (n_ferr !== 0) begin mis_cnt++; $display("FAIL midrst_ferr: got %0d want 0", n_ferr); end
  endtask

  task automatic test_baud_tolerance();
    int fall;
    int bc_tab[2];
    bc_tab[0] = 102;
    bc_tab[1] = 106;
    for (int k = 0; k < 2; k++) begin
      clear_counts();
      send_byte(8'h96, bc_tab[k], 1'b1, fall);
      idle(60);
      cmp_cnt++; if (n_valid !== 1) begin mis_cnt++; $display("FAIL baud%0d_count: got %0d want 1", bc_tab[k], n_valid); end
      cmp_cnt++; if (rise_dat !== 8'h96) begin mis_cnt++; $display("FAIL baud%0d_dat: got %h want 96", bc_tab[k], rise_dat); end
      cmp_cnt++; if (n_ferr !== 0) begin mis_cnt++; $display("FAIL baud%0d_ferr: got %0d want 0", bc_tab[k], n_ferr); end
    end
  endtask

  initial begin
    cmp_cnt    = 0;
    mis_cnt    = 0;
    cyc        = 0;
    t_valid    = 0;
    rise_dat   = 8'h00;
    prev_valid = 1'b0;
    rx         = 1'b1;
    ready      = 1'b1;
    rst_n      = 1'b0;
    clear_counts();
    test_reset();
    test_single();
    test_back_to_back_overrun();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_baud_tolerance();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
